// File: rtl/bcd_pkg.sv
// Shared BCD types, limits and helpers for the scan counter.
// Exports BCD_W, BCD_MAX, bcd_t and bcd_valid().
package bcd_pkg;

  localparam int   BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic logic bcd_valid(bcd_t v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One combinational BCD digit step: +1/-1 with carry/borrow out.
// Ports: d, step_in, up -> nxt, step_out.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_t d,
  input  logic step_in,
  input  logic up,
  output bcd_t nxt,
  output logic step_out
);

  always_comb begin
    nxt      = d;
    step_out = 1'b0;
    if (step_in) begin
      if (up) begin
        if (d >= BCD_MAX) begin
          nxt      = '0;
          step_out = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == '0) begin
          nxt      = BCD_MAX;
          step_out = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with parallel load and digit scanner.
// Ports: clk, rst, en, up, load, load_val -> count, tc, load_err, digit_sel, digit_bcd.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000,
  parameter int SCAN_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [3:0]            digit_bcd
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_t                cur [DIGITS];
  logic [4*DIGITS-1:0] nxt_v;
  logic [4*DIGITS-1:0] ld_v;
  logic [DIGITS-1:0]   bad_v;
  logic [DIGITS:0]     step;

  // step[0] is a constant request; en gates whether the result is used.
  assign step[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_t nib;
    bcd_t nx;
    assign cur[i]   = count[4*i +: 4];
    assign nib      = load_val[4*i +: 4];
    assign bad_v[i] = !bcd_valid(nib);
    assign ld_v[4*i +: 4] = bad_v[i] ? '0 : nib;
    assign nxt_v[4*i +: 4] = nx;

    bcd_digit_cell u_cell (
      .d        (cur[i]),
      .step_in  (step[i]),
      .up       (up),
      .nxt      (nx),
      .step_out (step[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      tc       <= 1'b0;
      if (load) begin
        count    <= ld_v;
        load_err <= |bad_v;
      end else if (en) begin
        count <= nxt_v;
        tc    <= step[DIGITS];
      end
    end
  end

  logic [SCAN_W-1:0] pre;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DIGITS-1:0] sel_nxt;
  logic              pre_wrap;

  always_comb begin
    pre_wrap = (pre == SCAN_W'(SCAN_DIV - 1));
    idx_nxt  = idx;
    if (pre_wrap) begin
      idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
    sel_nxt          = '0;
    sel_nxt[idx_nxt] = 1'b1;
  end

  // sel and bcd both follow idx_nxt so they always land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre       <= '0;
      idx       <= '0;
      digit_sel <= DIGITS'(1);
      digit_bcd <= '0;
    end else begin
      pre       <= pre_wrap ? '0 : pre + 1'b1;
      idx       <= idx_nxt;
      digit_sel <= sel_nxt;
      digit_bcd <= cur[idx_nxt];
    end
  end

endmodule
